// File: rtl/pic_window_buffer.sv
// Raster-stream KxK window generator with K+1 circular line buffers
// and per-frame selectable border padding (zero / replicate / reflect).
module pic_window_buffer #(
    parameter int DSIZE        = 8,
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_LENGTH = 256,
    parameter int KSIZE        = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic [1:0]                     pad_mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DSIZE-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DSIZE*KSIZE*KSIZE-1:0]   out_data,
    output logic                           out_first,
    output logic                           out_last
);

    localparam int W  = IMAGE_WIDTH;
    localparam int H  = IMAGE_LENGTH;
    localparam int K  = KSIZE;
    localparam int R  = (K - 1) / 2;
    localparam int LN = K + 1;
    localparam int CW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);
    localparam int LW = $clog2(LN);
    localparam int XW = $clog2(W);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]          state;
    logic [1:0]          pmode;
    logic [CW-1:0]       wr_col;
    logic [RW-1:0]       wr_row;
    logic [LW-1:0]       wr_line;
    logic [CW-1:0]       rd_col;
    logic [RW-1:0]       rd_row;
    logic                done_load;
    logic [DSIZE-1:0]    mem [LN][W];

    logic                in_fire;
    logic                out_fire;
    logic                wr_eol;
    logic                wr_eof;
    logic                rd_eol;
    logic                rd_eof;
    logic                eligible;
    logic                load;
    logic [DSIZE*K*K-1:0] win;

    assign wr_eol = (wr_col == CW'(W - 1));
    assign wr_eof = wr_eol && (wr_row == RW'(H - 1));
    assign rd_eol = (rd_col == CW'(W - 1));
    assign rd_eof = rd_eol && (rd_row == RW'(H - 1));

    // Writing row rd_row+R+1 only reuses the line of row rd_row-R-1,
    // which the window being built no longer needs.
    assign in_ready = rst_n && !frame_start && (state != DRAIN) &&
                      (int'(wr_row) <= int'(rd_row) + R + 1);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign eligible = (int'(rd_row) + R >= H - 1) ?
                      (wr_row == RW'(H)) :
                      (int'(wr_row) > int'(rd_row) + R);

    assign load = (state != IDLE) && !done_load && eligible &&
                  (!out_valid || out_ready) && !frame_start;

    function automatic int map_axis(input int v, input int n,
                                    input logic [1:0] m,
                                    output logic ok);
        ok       = 1'b1;
        map_axis = v;
        if (v < 0 || v >= n) begin
            if (m == 2'd1) begin
                map_axis = (v < 0) ? 0 : n - 1;
            end else if (m == 2'd2) begin
                map_axis = (v < 0) ? -v : 2 * (n - 1) - v;
            end else begin
                ok       = 1'b0;
                map_axis = 0;
            end
        end
    endfunction

    always_comb begin
        int   ty;
        int   tx;
        logic oky;
        logic okx;
        win = '0;
        ty  = 0;
        tx  = 0;
        oky = 1'b0;
        okx = 1'b0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                ty = map_axis(int'(rd_row) + ky - R, H, pmode, oky);
                tx = map_axis(int'(rd_col) + kx - R, W, pmode, okx);
                if (oky && okx) begin
                    win[(ky*K+kx)*DSIZE +: DSIZE] =
                        mem[LW'(ty % LN)][XW'(tx)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_line][XW'(wr_col)] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pmode     <= 2'd0;
            wr_col    <= '0;
            wr_row    <= '0;
            wr_line   <= '0;
            rd_col    <= '0;
            rd_row    <= '0;
            done_load <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (frame_start) begin
            state     <= IDLE;
            pmode     <= 2'd0;
            wr_col    <= '0;
            wr_row    <= '0;
            wr_line   <= '0;
            rd_col    <= '0;
            rd_row    <= '0;
            done_load <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                if (state == IDLE) begin
                    pmode <= pad_mode;
                end
                if (wr_eol) begin
                    wr_col  <= '0;
                    wr_row  <= wr_row + 1'b1;
                    wr_line <= (wr_line == LW'(LN - 1)) ? '0 :
                               wr_line + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
                if (wr_eof) begin
                    state <= DRAIN;
                end else if (state == IDLE) begin
                    state <= FILL;
                end else if (state == FILL && wr_eol &&
                             wr_row == RW'(R)) begin
                    state <= STREAM;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= win;
                out_first <= (rd_row == '0) && (rd_col == '0);
                out_last  <= rd_eof;
                if (rd_eof) begin
                    done_load <= 1'b1;
                end else if (rd_eol) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 1'b1;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end

            // Last window accepted: frame done, ready for the next one.
            if (out_fire && out_last) begin
                state     <= IDLE;
                wr_col    <= '0;
                wr_row    <= '0;
                wr_line   <= '0;
                rd_col    <= '0;
                rd_row    <= '0;
                done_load <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pic_window_buffer.sv
// Randomised bench for pic_window_buffer: 4x4/K3 and 5x5/K5 instances
// checked against a coordinate-level window model.
module tb_pic_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       frame_start;
    logic [1:0] pad_mode;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    int         sel;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic         a_out_first, a_out_last;
    logic [71:0]  a_out_data;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic         b_out_first, b_out_last;
    logic [199:0] b_out_data;

    logic         g_in_ready, g_out_valid, g_out_first, g_out_last;
    logic [199:0] g_out_data;

    assign a_in_valid  = in_valid && (sel == 0);
    assign a_out_ready = out_ready && (sel == 0);
    assign b_in_valid  = in_valid && (sel == 1);
    assign b_out_ready = out_ready && (sel == 1);

    assign g_in_ready  = (sel == 1) ? b_in_ready  : a_in_ready;
    assign g_out_valid = (sel == 1) ? b_out_valid : a_out_valid;
    assign g_out_first = (sel == 1) ? b_out_first : a_out_first;
    assign g_out_last  = (sel == 1) ? b_out_last  : a_out_last;
    assign g_out_data  = (sel == 1) ? b_out_data  : {128'b0, a_out_data};

    pic_window_buffer #(
        .DSIZE(8), .IMAGE_WIDTH(4), .IMAGE_LENGTH(4), .KSIZE(3)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pad_mode(pad_mode), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_first(a_out_first),
        .out_last(a_out_last)
    );

    pic_window_buffer #(
        .DSIZE(8), .IMAGE_WIDTH(5), .IMAGE_LENGTH(5), .KSIZE(5)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pad_mode(pad_mode), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_first(b_out_first),
        .out_last(b_out_last)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int nlast;
    logic [199:0] got [25];

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pix(int seed, int w, int r, int c);
        if (seed == 0) return w * r + c + 1;
        return (r * 37 + c * 11 + seed * 53 + r * c * 7) & 255;
    endfunction

    function automatic logic [199:0] model(int seed, int w, int h, int k,
                                           int mode, int r, int c);
        logic [199:0] res;
        int rr, y, x;
        bit ok;
        res = '0;
        rr  = (k - 1) / 2;
        for (int ky = 0; ky < k; ky++) begin
            for (int kx = 0; kx < k; kx++) begin
                y  = r + ky - rr;
                x  = c + kx - rr;
                ok = 1;
                if (mode == 1) begin
                    y = (y < 0) ? 0 : ((y > h - 1) ? h - 1 : y);
                    x = (x < 0) ? 0 : ((x > w - 1) ? w - 1 : x);
                end else if (mode == 2) begin
                    if (y < 0) y = -y;
                    if (y > h - 1) y = 2 * (h - 1) - y;
                    if (x < 0) x = -x;
                    if (x > w - 1) x = 2 * (w - 1) - x;
                end else begin
                    ok = (y >= 0 && y < h && x >= 0 && x < w);
                end
                if (ok) res[(ky*k+kx)*8 +: 8] = 8'(pix(seed, w, y, x));
            end
        end
        return res;
    endfunction

    function automatic logic [199:0] pk9(int t0, int t1, int t2, int t3,
                                         int t4, int t5, int t6, int t7,
                                         int t8);
        logic [199:0] res;
        res = '0;
        res[71:0] = {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4),
                     8'(t3), 8'(t2), 8'(t1), 8'(t0)};
        return res;
    endfunction

    task automatic run(input int mode, input int frames, input int seed0,
                       input int vp, input int rp, input int stall);
        int w, h, k, n, rr, pin, wout, fr, p;
        logic [255:0] held;
        logic stalled;
        w = (sel == 1) ? 5 : 4;
        h = w;
        k = (sel == 1) ? 5 : 3;
        n = w * h;
        rr = (k - 1) / 2;
        pin = 0;
        wout = 0;
        stalled = 1'b0;
        held = '0;
        nlast = 0;
        for (int cyc = 0; cyc < 3000 && wout < frames * n; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= stall) && ($urandom_range(99) < rp);
            if (pin < frames * n) begin
                fr = pin / n;
                p  = pin % n;
                in_valid = (cyc < stall) || ($urandom_range(99) < vp);
                in_data  = 8'(pix(seed0 + fr, w, p / w, p % w));
                pad_mode = (p == 0) ? 2'(mode) : 2'($urandom_range(3));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (g_out_valid && stalled)
                chk("hold", {g_out_first, g_out_last, g_out_data}, held);
            stalled = g_out_valid && !out_ready;
            held = {g_out_first, g_out_last, g_out_data};
            if (stall > 0 && cyc == stall - 1) begin
                chk("bp_accepted", pin, (rr + 2) * w);
                chk("bp_in_ready", g_in_ready, 0);
                chk("bp_out_valid", g_out_valid, 1);
            end
            if (in_valid && g_in_ready) pin++;
            if (g_out_valid && out_ready) begin
                fr = wout / n;
                p  = wout % n;
                chk("window", g_out_data,
                    model(seed0 + fr, w, h, k, mode, p / w, p % w));
                chk("first", g_out_first, p == 0);
                chk("last", g_out_last, p == n - 1);
                if (fr == 0) got[p] = g_out_data;
                nlast += int'(g_out_last);
                wout++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("count", wout, frames * n);
        chk("last_pulses", nlast, frames);
    endtask

    task automatic abort(input int npix, input bit use_rst);
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < 200 && sent < npix; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'(pix(0, 4, sent / 4, sent % 4));
            pad_mode  = 2'd0;
            #1;
            if (g_in_ready) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (use_rst) rst_n = 1'b0;
        else frame_start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        frame_start = 1'b0;
        #1;
        chk("abort_out_valid", g_out_valid, 0);
        chk("abort_in_ready", g_in_ready, 1);
        if (use_rst) chk("abort_out_data", g_out_data, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        pad_mode = 2'd0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 8'd0;
        sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_in_ready", g_in_ready, 0);
            chk("rst_out_valid", g_out_valid, 0);
            chk("rst_flags", {g_out_first, g_out_last}, 0);
            chk("rst_out_data", g_out_data, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("post_rst_in_ready", g_in_ready, 1);
        end
        sel = 0;

        run(0, 1, 0, 100, 100, 0);
        chk("zero_00", got[0], pk9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("zero_11", got[5], pk9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        run(1, 1, 0, 70, 70, 0);
        chk("rep_00", got[0], pk9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        chk("rep_33", got[15], pk9(11, 12, 12, 15, 16, 16, 15, 16, 16));
        run(2, 1, 0, 60, 80, 0);
        chk("refl_00", got[0], pk9(6, 5, 6, 2, 1, 2, 6, 5, 6));
        chk("refl_03", got[3], pk9(7, 8, 7, 3, 4, 3, 7, 8, 7));
        run(0, 1, 0, 100, 100, 30);
        run(3, 2, 5, 50, 50, 0);

        abort(7, 1'b0);
        run(1, 1, 0, 100, 100, 0);
        chk("abort_fs_rep_00", got[0], pk9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        abort(7, 1'b1);
        run(1, 1, 0, 100, 100, 0);
        chk("abort_rst_rep_00", got[0], pk9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        abort(14, 1'b0);
        run(2, 1, 9, 60, 60, 0);

        sel = 1;
        run(2, 2, 0, 100, 100, 0);
        chk("k5_centre", got[0][103:96], 1);
        chk("k5_corner", got[0][7:0], 13);
        run(2, 2, 3, 60, 60, 0);
        run(1, 1, 7, 50, 90, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pic_window_buffer.md
Name: pic_window_buffer

Overview:
- Parametrised successor to the fixed 3x3 kernel buffer. Receives a raster-scan pixel stream over a valid/ready handshake and stores it in K+1 circular line buffers.
- Emits one KSIZE x KSIZE window per image pixel, centred on that pixel, with runtime-selectable border padding (zero / replicate / reflect).
- Supports backpressure on both sides. Sits between the pixel source and the kernel/RNG datapath.

Parameters:
- DSIZE, 8, pixel width in bits.
- IMAGE_WIDTH, 256, pixels per row W; must be >= KSIZE.
- IMAGE_LENGTH, 256, rows per frame H; must be >= KSIZE.
- KSIZE, 3, window edge K; odd, 3..7. R = (K-1)/2.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- frame_start, input, 1, synchronous frame abort/restart.
- pad_mode, input, 2, padding mode: 0 zero, 1 replicate, 2 reflect, 3 treated as zero.
- in_valid, input, 1, input pixel valid.
- in_ready, output, 1, buffer can accept a pixel.
- in_data, input, DSIZE, pixel value, raster order.
- out_valid, output, 1, window valid.
- out_ready, input, 1, consumer accepts the window.
- out_data, output, DSIZE*K*K, window. Tap i = ky*K+kx occupies bits [(i+1)*DSIZE-1 : i*DSIZE]; ky=0 is the top row, kx=0 the left column.
- out_first, output, 1, qualifies the window centred at (0,0).
- out_last, output, 1, qualifies the window centred at (H-1,W-1).

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_first=0, out_last=0, out_data=0; all counters 0; state IDLE; in_ready=0 during reset, 1 in the first cycle after.
- frame_start: lower priority than reset, higher than any handshake. Same effect as reset except out_data holds its value. Any in-flight window is dropped.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data, out_first and out_last are held stable.
- Write side: counters wr_col/wr_row advance per input transfer. wr_col wraps at W-1 into wr_row+1.
- Read side: counters rd_col/rd_row give the current output centre; they advance per output transfer.
- State machine:
  - IDLE -> FILL on the first input transfer. pad_mode is sampled at this transfer and held for the whole frame.
  - FILL -> STREAM once rows 0..R are fully written.
  - STREAM -> DRAIN once row H-1 is fully written.
  - DRAIN -> IDLE on the output transfer carrying out_last.
- in_ready = (state != DRAIN) && (wr_row <= rd_row + R + 1). This guarantees a line still referenced by the current centre's window is never overwritten.
- Window for centre row r becomes eligible when all rows up to min(r+R, H-1) are fully written.
- out_valid rises exactly 1 cycle after eligibility, or 1 cycle after the previous output transfer. out_data is registered.
- Full throughput: with out_ready=1 held, one window per cycle is sustained in STREAM and DRAIN.
- Out-of-range tap coordinate (y, x), per axis:
  - zero: tap value = 0.
  - replicate: clamp to the range [0, N-1].
  - reflect (no edge repeat): -d -> d, N-1+d -> N-1-d.
- Centre tap (i = R*K+R) is never padded.
- Exactly W*H windows per frame.
- After the last input pixel, in_ready=0 until IDLE is re-entered. Back-to-back frames need no idle cycle beyond this.
- Counters are sized $clog2(W+1) and $clog2(H+1); no wrap beyond W-1 / H-1.

Test Plan (W=4, H=4, K=3, pixel(r,c) = 4r+c+1, out_ready=1 unless stated):
- Zero pad, full stream: window (0,0) = [0,0,0, 0,1,2, 0,5,6], out_first=1. Window (1,1) = [1,2,3, 5,6,7, 9,10,11]. Exactly 16 windows.
- Replicate: (0,0) = [1,1,2, 1,1,2, 5,5,6]. (3,3) = [11,12,12, 15,16,16, 15,16,16] with out_last=1.
- Reflect: (0,0) = [6,5,6, 2,1,2, 6,5,6]. (0,3) = [7,8,7, 3,4,3, 7,8,7].
- Backpressure: out_ready=0 with in_valid=1 continuous.
  - Exactly 12 pixels accepted (rows 0..2), then in_ready=0.
  - out_valid=1 with window (0,0) held stable for 20 cycles.
  - Releasing out_ready then completes all 16 windows in order.
- Abort: frame_start asserted after 7 input pixels.
  - out_valid=0 the next cycle.
  - A fresh frame in replicate mode yields (0,0) = [1,1,2, 1,1,2, 5,5,6].
  - Same sequence repeated with rst_n=0 instead of frame_start.
- K=5, reflect mode, 5x5 image (W=H=5), two back-to-back frames:
  - 25 windows each.
  - (0,0) centre tap = 1 and corner tap (ky=0,kx=0) = pixel(2,2) = 13.
  - out_last pulses twice.
